vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
- Shares one synchronous single-port frame-buffer RAM between two users: the video scan-out path and a host port.
- Video scan-out is 1 bpp, with one DATA_W-bit word every 8 pixels. The host port does reads and writes.
- Runs from the same clk and the hpos/vpos/display_on outputs of the VGA sync generator.
- Schedules video fetches on fixed slots ahead of the beam, serves the host in all other cycles, and produces the serialized pixel stream.
- Latches the scroll/base address once per frame.

Parameters:
- ADDR_W, 16: RAM address width.
- DATA_W, 8: RAM word width; equals pixels per fetch (fixed at 8).
- H_DISPLAY, 640: visible pixels per line.
- H_TOTAL, 800: clocks per line (multiple of 8).
- V_DISPLAY, 480: visible lines.
- V_TOTAL, 525: lines per frame.
- WORDS_PER_LINE, 80: H_DISPLAY/8.

Ports:
- clk, input, 1: pixel clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- hpos, input, 10: current column from the sync generator.
- vpos, input, 10: current line from the sync generator.
- display_on, input, 1: visible-area flag from the sync generator.
- cfg_base, input, ADDR_W: frame base address. Sampled once per frame.
- host_req, input, 1: host request. Held, with all fields stable, until host_ack.
- host_we, input, 1: 1 = write, 0 = read.
- host_addr, input, ADDR_W: host address.
- host_wdata, input, DATA_W: host write data.
- host_ack, output, 1: request issued to RAM this cycle.
- host_rvalid, output, 1: read data valid.
- host_rdata, output, DATA_W: read data.
- mem_en, output, 1: RAM enable.
- mem_we, output, 1: RAM write enable.
- mem_addr, output, ADDR_W: RAM address.
- mem_wdata, output, DATA_W: RAM write data.
- mem_rdata, input, DATA_W: RAM read data, valid the cycle after mem_en with mem_we=0.
- pixel, output, 1: current pixel, gated by display_on.
- frame_start, output, 1: one-cycle pulse on the frame's first video fetch.

Behaviour:
- Reset (rst_n low, async): all registers clear.
  - Shift register, fetched-word register, video offset counter, latched base and host_rvalid reg are all 0.
  - Outputs: pixel=0, host_ack=0, host_rvalid=0, mem_en=0, frame_start=0.
  - Reset mid-line: the first valid fetch after release waits for the next scheduled slot. Pixels before that are 0.
- Video fetch slot (vslot) is combinational from hpos/vpos and occurs when hpos[2:0]==5 and one of these holds:
  - (a) hpos < H_DISPLAY-8 and vpos < V_DISPLAY: next column of the current line.
  - (b) hpos == H_TOTAL-3 and next line < V_DISPLAY. The next line is vpos+1, or 0 when vpos==V_TOTAL-1. This is column 0 of the next line.
- Video addressing:
  - A vslot drives mem_en=1, mem_we=0, mem_addr = base + offset (mod 2^ADDR_W), then increments offset.
  - First-fetch vslot (hpos==H_TOTAL-3, vpos==V_TOTAL-1):
    - uses cfg_base directly with offset 0;
    - latches base <= cfg_base and sets offset <= 1;
    - asserts frame_start.
  - A cfg_base change at any other time has no effect until the next frame.
- Word capture and serialization:
  - On the edge ending hpos[2:0]==6, the fetched-word register <= mem_rdata, if a vslot occurred in the previous cycle.
  - On the edge ending hpos[2:0]==7, the shift register <= fetched word. On all other edges it shifts left, filling with 0.
  - pixel = shreg[DATA_W-1] & display_on, so the word's MSB is the leftmost pixel (hpos%8==0).
  - Pipeline latency is fetch at h, data at h+1, load at h+2, first pixel at h+3.
- Host arbitration:
  - Video has absolute priority.
  - host_ack = host_req & ~vslot, combinational. In that cycle mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - Worst-case host wait is 1 cycle, since vslots are never adjacent.
  - With no vslot and no host_req, mem_en=0.
- Host read return:
  - host_rvalid is high in the cycle after a read ack, with host_rdata = mem_rdata.
  - Back-to-back reads pipeline, one per cycle.
  - The host must hold host_req until it sees host_ack. Dropping it earlier is illegal, and behaviour is then undefined.
- Blanking: with no vslots (vertical blank, hpos ≥ H_DISPLAY-8 other than the column-0 slot), the host may issue every cycle.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> all outputs 0. Release at hpos=100 -> first mem_en at hpos=101 (its hpos%8==5), addr reflects the offset counter.
- Frame start: cfg_base=0x1000, RAM[a]=a[7:0]; run one frame. Required:
  - frame_start at (hpos=797, vpos=524) with mem_addr=0x1000;
  - the line 0 column 1 fetch at hpos=5 reads 0x1001;
  - the last fetch is 0x1000+38399;
  - exactly 38400 fetches per frame.
- Pixel serialization: RAM[0x1000]=0xA5 -> line 0 pixels at hpos 0..7 are 1,0,1,0,0,1,0,1. pixel=0 whenever display_on=0.
- Collision: host_req held, asserted at a cycle with hpos=13 (vslot), vpos=10 -> host_ack=0 at hpos=13, host_ack=1 at hpos=14, and video data is unaffected.
- Host read/write: during vertical blank (vpos=500), write 0x3C to 0x0042, then read 0x0042 -> host_rvalid one cycle after the read ack, host_rdata=0x3C. 4 back-to-back reads give 4 consecutive rvalid pulses.
- Base latch: change cfg_base to 0x2000 at vpos=200 -> the remaining fetches of the current frame keep base 0x1000. The next frame's first fetch is 0x2000.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// rtl/vga_mem_arbiter_if.sv - host request port and frame-buffer RAM port of the VGA memory arbiter
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master: the arbiter, which answers the host and drives the RAM
  modport master (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output host_ack, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // slave: the host plus the RAM on the far side of the arbiter
  modport slave (
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  host_ack, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - single-port frame-buffer sharing between 1 bpp scan-out and a host port
module vga_mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int H_DISPLAY      = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_DISPLAY      = 480,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              pixel,
  output logic              frame_start,
  vga_mem_arbiter_if.master bus
);

  localparam logic [9:0] H_COL_END   = 10'(H_DISPLAY - 8);
  localparam logic [9:0] H_COL_LAST  = 10'(WORDS_PER_LINE * 8 - 3);
  localparam logic [9:0] H_WRAP_SLOT = 10'(H_TOTAL - 3);
  localparam logic [9:0] V_VIS       = 10'(V_DISPLAY);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  logic              active_q;
  logic              vslot_q;
  logic              rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic [9:0] next_line;
  logic       slot_col, slot_wrap, vslot, first_fetch;

  // A fetch sits three clocks ahead of the first pixel it feeds; the wrap
  // slot near end of line fetches column 0 of the following line.
  always_comb begin
    next_line   = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    slot_col    = (hpos[2:0] == 3'd5) && (hpos < H_COL_END) &&
                  (hpos <= H_COL_LAST) && (vpos < V_VIS);
    slot_wrap   = (hpos[2:0] == 3'd5) && (hpos == H_WRAP_SLOT) && (next_line < V_VIS);
    vslot       = active_q & (slot_col | slot_wrap);
    first_fetch = vslot && (hpos == H_WRAP_SLOT) && (vpos == V_LAST);
  end

  assign frame_start     = first_fetch;
  assign bus.host_ack    = active_q & bus.host_req & ~vslot;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = bus.mem_rdata;
  assign pixel           = shreg_q[DATA_W-1] & display_on;

  always_comb begin
    bus.mem_en    = vslot | bus.host_ack;
    bus.mem_we    = bus.host_ack & bus.host_we;
    bus.mem_wdata = bus.host_wdata;
    if (first_fetch)
      bus.mem_addr = cfg_base;
    else if (vslot)
      bus.mem_addr = base_q + offset_q;
    else
      bus.mem_addr = bus.host_addr;
  end

  always_comb begin
    base_d   = base_q;
    offset_d = offset_q;
    if (first_fetch) begin
      base_d   = cfg_base;
      offset_d = ADDR_W'(1);
    end else if (vslot) begin
      offset_d = offset_q + ADDR_W'(1);
    end

    word_d = word_q;
    if ((hpos[2:0] == 3'd6) && vslot_q)
      word_d = bus.mem_rdata;

    if (hpos[2:0] == 3'd7)
      shreg_d = word_q;
    else
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};

    rvalid_d = bus.host_ack & ~bus.host_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      vslot_q  <= 1'b0;
      rvalid_q <= 1'b0;
      base_q   <= '0;
      offset_q <= '0;
      word_q   <= '0;
      shreg_q  <= '0;
    end else begin
      active_q <= 1'b1;
      vslot_q  <= vslot;
      rvalid_q <= rvalid_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      word_q   <= word_d;
      shreg_q  <= shreg_d;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - scoreboard bench for vga_mem_arbiter on a shrunken raster
module tb_vga_mem_arbiter;
  localparam int H_DISPLAY = 64;
  localparam int H_TOTAL   = 96;
  localparam int V_DISPLAY = 8;
  localparam int V_TOTAL   = 12;
  localparam int WPL       = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hpos = 10'd0;
  logic [9:0]  vpos = 10'd0;
  logic        display_on;
  logic [15:0] cfg_base = 16'h1000;
  logic        pixel, frame_start;

  vga_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  vga_mem_arbiter #(
    .ADDR_W(16), .DATA_W(8), .H_DISPLAY(H_DISPLAY), .H_TOTAL(H_TOTAL),
    .V_DISPLAY(V_DISPLAY), .V_TOTAL(V_TOTAL), .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .cfg_base(cfg_base), .pixel(pixel), .frame_start(frame_start), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hpos == 10'(H_TOTAL - 1)) begin
      hpos <= 10'd0;
      vpos <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end
  assign display_on = (hpos < 10'(H_DISPLAY)) && (vpos < 10'(V_DISPLAY));

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (hpos=%0d vpos=%0d)", name, act, exp, hpos, vpos);
    end
  endtask

  logic live;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Reference model: a fetch is due whenever the pixel three clocks ahead
  // starts a visible word; its address is frame base + line*WPL + word.
  int          h3, v3, fetch_cnt, rv_run, rv_max;
  logic        ev, efirst, synced, rd_prev, fcount_valid;
  logic [15:0] fb, pre_cnt, eaddr, last_addr, prev_fb;
  logic [7:0]  pix_byte;
  logic [7:0]  rd_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      synced = 1'b0; pre_cnt = 16'd0; rd_prev = 1'b0;
      fcount_valid = 1'b0; fetch_cnt = 0; rv_run = 0;
    end else if (live) begin
      h3 = int'(hpos) + 3;
      v3 = int'(vpos);
      if (h3 >= H_TOTAL) begin
        h3 -= H_TOTAL;
        v3 = (int'(vpos) + 1) % V_TOTAL;
      end
      ev     = (v3 < V_DISPLAY) && (h3 < H_DISPLAY) && (h3 % 8 == 0);
      efirst = ev && (h3 == 0) && (v3 == 0);
      if (efirst) begin
        fb = cfg_base;
        synced = 1'b1;
      end

      if (ev) begin
        eaddr = synced ? 16'(int'(fb) + v3 * WPL + h3 / 8) : pre_cnt;
        pre_cnt++;
        chk("video_fetch", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.host_ack, frame_start},
            {1'b1, 1'b0, eaddr, 1'b0, efirst});
      end else if (bus.host_req) begin
        chk("host_issue", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.host_ack, frame_start},
            {1'b1, bus.host_we, bus.host_addr, 1'b1, 1'b0});
        if (bus.host_we) chk("host_wdata", bus.mem_wdata, bus.host_wdata);
      end else begin
        chk("mem_idle", {bus.mem_en, bus.host_ack, frame_start}, 3'b000);
      end

      chk("rvalid_timing", bus.host_rvalid, rd_prev);
      rd_prev = bus.host_req && !ev && !bus.host_we;

      if (bus.host_rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL host_rdata_unexpected actual=%0h required=none", bus.host_rdata);
        end else begin
          chk("host_rdata", bus.host_rdata, rd_q.pop_front());
        end
        rv_run++;
        if (rv_run > rv_max) rv_max = rv_run;
      end else begin
        rv_run = 0;
      end

      if (!display_on)
        chk("pixel_blank", pixel, 1'b0);
      else if (synced)
        chk("pixel", pixel, ref_mem[16'(int'(fb) + int'(vpos) * WPL + int'(hpos) / 8)][7 - int'(hpos) % 8]);

      if (synced && vpos == 10'd0 && hpos < 10'd8) pix_byte[7 - int'(hpos)] = pixel;
      if (synced && vpos == 10'd0 && hpos == 10'd8) chk("line0_word", pix_byte, ref_mem[fb]);

      if (frame_start) begin
        chk("frame_start_pos", {hpos, vpos, bus.mem_addr},
            {10'(H_TOTAL - 3), 10'(V_TOTAL - 1), cfg_base});
        if (fcount_valid) begin
          chk("fetches_per_frame", fetch_cnt, V_DISPLAY * WPL);
          chk("last_fetch_addr", last_addr, 16'(int'(prev_fb) + V_DISPLAY * WPL - 1));
        end
        fcount_valid = 1'b1;
        fetch_cnt = 1;
        prev_fb = fb;
        last_addr = bus.mem_addr;
      end else if (bus.mem_en && !bus.mem_we && !bus.host_ack) begin
        fetch_cnt++;
        last_addr = bus.mem_addr;
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    bit found = 1'b0;
    for (int i = 0; i < 3 * H_TOTAL * V_TOTAL && !found; i++) begin
      @(negedge clk);
      if (int'(hpos) == h && int'(vpos) == v) found = 1'b1;
    end
    chk("wait_pos_reached", found, 1'b1);
  endtask

  // Starts just after a posedge, holds the request until acked, returns
  // just after the posedge that completes the transfer.
  task automatic do_host(input logic we, input logic [15:0] a, input logic [7:0] d, output int ack_h);
    int waited = -1;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    ack_h = -1;
    for (int i = 0; i < 8 && waited < 0; i++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        waited = i;
        ack_h = int'(hpos);
        if (we) ref_mem[a] = d;
        else    rd_q.push_back(ref_mem[a]);
      end
    end
    chk("host_wait_le_1", (waited >= 0) && (waited <= 1), 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int ah, fh;
    logic [15:0] fa;
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[16'h1000] = 8'hA5;
    ref_mem[16'h1000] = 8'hA5;

    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0; bus.host_wdata = 8'h0;
    rv_max = 0;

    repeat (12) begin
      @(negedge clk);
      chk("reset_outputs", {pixel, bus.host_ack, bus.host_rvalid, bus.mem_en, frame_start}, 5'b0);
    end
    bus.host_req = 1'b0;

    wait_pos(35, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fh = -1; fa = 16'hFFFF;
    for (int i = 0; i < 16 && fh < 0; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        fh = int'(hpos);
        fa = bus.mem_addr;
      end
    end
    chk("first_fetch_hpos", fh, 37);
    chk("first_fetch_addr", fa, 16'h0000);

    wait_pos(H_TOTAL - 3, V_TOTAL - 1);
    @(posedge clk); #1;

    for (int n = 0; n < 1200; n++) begin
      do_host(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 8'($urandom), ah);
      if ($urandom_range(0, 3) == 0) begin
        bus.host_req = 1'b0;
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
    end
    bus.host_req = 1'b0;

    wait_pos(12, 3);
    @(posedge clk); #1;
    do_host(1'b0, 16'h0010, 8'h00, ah);
    chk("collision_ack_hpos", ah, 14);
    bus.host_req = 1'b0;

    wait_pos(0, 9);
    @(posedge clk); #1;
    rv_max = 0;
    do_host(1'b1, 16'h0042, 8'h3C, ah);
    do_host(1'b0, 16'h0042, 8'h00, ah);
    for (int n = 0; n < 4; n++) do_host(1'b0, 16'($urandom_range(0, 255)), 8'h00, ah);
    bus.host_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rvalid_run_length", rv_max, 5);
    chk("blank_write_landed", ram[16'h0042], 8'h3C);

    wait_pos(0, 4);
    cfg_base = 16'h2000;
    wait_pos(H_TOTAL - 3, V_TOTAL - 1);
    chk("new_base_first_fetch", {frame_start, bus.mem_addr}, {1'b1, 16'h2000});
    wait_pos(H_TOTAL - 3, V_TOTAL - 1);
    repeat (4) @(negedge clk);

    chk("rd_queue_empty", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
